mprj_io_bank: RTL



---
 rtl/mprj_io_pkg.sv | 21 ++
 rtl/mprj_io_bank_if.sv | 14 +
 rtl/mprj_io_slice.sv | 90 +++++++++
 rtl/mprj_io_bank.sv | 73 +++++++
 4 files changed

// File: rtl/mprj_io_pkg.sv
// Shared constants and the per-pad configuration word for the mprj GPIO bank.
// The word is loaded serially into a shadow chain, then applied atomically.
package mprj_io_pkg;

    localparam int CFG_W       = 6;
    localparam int CFG_OUT_DIS = 0;
    localparam int CFG_INP_DIS = 1;
    localparam int CFG_DM_LSB  = 2;
    localparam int CFG_FILT_EN = 5;

    typedef struct packed {
        logic       filt_en;
        logic [2:0] dm;
        logic       inp_dis;
        logic       out_dis;
    } io_cfg_t;

    // Output disabled, input enabled, dm = 3'b001, filter off.
    localparam io_cfg_t CFG_RESET = 6'b000101;

endpackage

// File: rtl/mprj_io_bank_if.sv
// Pad-side bundle between the GPIO bank and the pc3b03ed_wrapper pad cells.
// The master modport is the bank; the slave modport is the pad array.
interface mprj_io_bank_if #(parameter int PADS = 38);

    logic [PADS-1:0]   pad_out;
    logic [PADS-1:0]   pad_oeb;
    logic [PADS-1:0]   pad_inp_dis;
    logic [3*PADS-1:0] pad_dm;
    logic [PADS-1:0]   pad_in;

    modport master (output pad_out, pad_oeb, pad_inp_dis, pad_dm, input pad_in);
    modport slave  (input pad_out, pad_oeb, pad_inp_dis, pad_dm, output pad_in);

endinterface

// File: rtl/mprj_io_slice.sv
// One pad of the GPIO bank: active config, input synchroniser, glitch filter,
// edge detector and sticky interrupt-pending flag.
module mprj_io_slice
    import mprj_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_load,
    input  io_cfg_t    shadow_cfg,
    input  logic       core_out,
    input  logic       core_oeb,
    input  logic       pad_in,
    input  logic       irq_clr,
    output logic       pad_out,
    output logic       pad_oeb,
    output logic       pad_inp_dis,
    output logic [2:0] pad_dm,
    output logic       core_in,
    output logic       irq_pending
);

    localparam int FW = $clog2(FILT_CYCLES + 1);
    // A counting filter needs one extra arming sample beyond the stable run.
    localparam logic [FW-1:0] FILT_TH = (FILT_CYCLES >= 2) ? FW'(FILT_CYCLES) : '0;

    io_cfg_t                cfg_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          cnt_q;
    logic                   filt_q;
    logic                   filt_d_q;
    logic                   sync_val;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cfg_q <= CFG_RESET;
        else if (serial_load)
            cfg_q <= shadow_cfg;
    end

    assign pad_out     = core_out;
    assign pad_oeb     = core_oeb | cfg_q[CFG_OUT_DIS];
    assign pad_inp_dis = cfg_q[CFG_INP_DIS];
    assign pad_dm      = cfg_q[CFG_DM_LSB +: 3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in & ~cfg_q[CFG_INP_DIS]};
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (!cfg_q[CFG_FILT_EN]) begin
            filt_q <= sync_val;
            cnt_q  <= '0;
        end else if (sync_val == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == FILT_TH) begin
            filt_q <= sync_val;
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + FW'(1);
        end
    end

    assign core_in = filt_q;

    // A new edge outranks a same-cycle clear so no event is ever lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_d_q    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            filt_d_q <= filt_q;
            if (filt_q != filt_d_q)
                irq_pending <= 1'b1;
            else if (irq_clr)
                irq_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mprj_io_bank.sv
// Registered GPIO bank controller: serial config shadow chain, one slice per
// pad and the combined interrupt request.
module mprj_io_bank
    import mprj_io_pkg::*;
#(
    parameter int PADS        = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            serial_shift,
    input  logic            serial_data_in,
    input  logic            serial_load,
    output logic            serial_data_out,
    input  logic [PADS-1:0] core_out,
    input  logic [PADS-1:0] core_oeb,
    output logic [PADS-1:0] core_in,
    input  logic [PADS-1:0] irq_en,
    input  logic [PADS-1:0] irq_clr,
    output logic [PADS-1:0] irq_pending,
    output logic            irq,
    mprj_io_bank_if.master  pads
);

    localparam int SW = PADS * CFG_W;

    logic [SW-1:0]     shadow_q;
    logic [PADS-1:0]   pad_out_w;
    logic [PADS-1:0]   pad_oeb_w;
    logic [PADS-1:0]   pad_inp_dis_w;
    logic [3*PADS-1:0] pad_dm_w;

    // First bit shifted in migrates to the MSB, i.e. the last pad's bit 5.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            shadow_q <= {PADS{CFG_RESET}};
        else if (serial_shift)
            shadow_q <= {shadow_q[SW-2:0], serial_data_in};
    end

    assign serial_data_out = shadow_q[SW-1];

    for (genvar i = 0; i < PADS; i++) begin : g_slice
        mprj_io_slice #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_slice (
            .clock       (clock),
            .reset       (reset),
            .serial_load (serial_load),
            .shadow_cfg  (io_cfg_t'(shadow_q[CFG_W*i +: CFG_W])),
            .core_out    (core_out[i]),
            .core_oeb    (core_oeb[i]),
            .pad_in      (pads.pad_in[i]),
            .irq_clr     (irq_clr[i]),
            .pad_out     (pad_out_w[i]),
            .pad_oeb     (pad_oeb_w[i]),
            .pad_inp_dis (pad_inp_dis_w[i]),
            .pad_dm      (pad_dm_w[3*i +: 3]),
            .core_in     (core_in[i]),
            .irq_pending (irq_pending[i])
        );
    end

    assign pads.pad_out     = pad_out_w;
    assign pads.pad_oeb     = pad_oeb_w;
    assign pads.pad_inp_dis = pad_inp_dis_w;
    assign pads.pad_dm      = pad_dm_w;

    assign irq = |(irq_pending & irq_en);

endmodule
